// File: rtl/branch_resolve_predictor.sv
// Fetch-side BTB predictor with 2-bit counters.
// Resolves against ID, trains the table and raises a registered redirect.
module branch_resolve_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Fetch_PC_IN,
    input  logic        Fetch_Valid_IN,
    input  logic        FREEZE_IN,
    output logic        Pred_Taken_OUT,
    output logic [31:0] Pred_Target_OUT,
    input  logic        ID_Valid_IN,
    input  logic [31:0] ID_PC_IN,
    input  logic [31:0] ID_Fallthrough_PC_IN,
    input  logic        is_branch,
    input  logic        is_taken,
    input  logic [31:0] Alt_PC,
    output logic        Mispredict_OUT,
    output logic [31:0] Correct_PC_OUT,
    output logic [31:0] Branch_Count_OUT,
    output logic [31:0] Mispredict_Count_OUT
);

    localparam int N  = 1 << IDX_BITS;
    localparam int TW = 30 - IDX_BITS;

    logic          valid_q [N];
    logic [TW-1:0] tag_q   [N];
    logic [31:0]   tgt_q   [N];
    logic [1:0]    ctr_q   [N];

    logic          inf_v_q;
    logic [31:0]   inf_pc_q;
    logic          inf_pt_q;
    logic [31:0]   inf_ptgt_q;

    logic          mis_q;
    logic [31:0]   cpc_q;
    logic [31:0]   bcnt_q;
    logic [31:0]   mcnt_q;

    logic [IDX_BITS-1:0] f_idx;
    logic [TW-1:0]       f_tag;
    logic                f_hit;
    logic [IDX_BITS-1:0] id_idx;
    logic [TW-1:0]       id_tag;
    logic                id_hit;

    logic        resolve;
    logic        eff_pt;
    logic [31:0] eff_ptgt;
    logic        mis_d;
    logic [31:0] cpc_d;
    logic        capture;

    assign f_idx  = Fetch_PC_IN[IDX_BITS+1:2];
    assign f_tag  = Fetch_PC_IN[31:IDX_BITS+2];
    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign id_idx = ID_PC_IN[IDX_BITS+1:2];
    assign id_tag = ID_PC_IN[31:IDX_BITS+2];
    assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

    assign Pred_Taken_OUT  = f_hit && ctr_q[f_idx][1];
    assign Pred_Target_OUT = Pred_Taken_OUT ? tgt_q[f_idx] : 32'd0;

    assign resolve = ID_Valid_IN && !FREEZE_IN;

    // Prediction only counts if it was made for this exact instruction
    always_comb begin
        eff_pt   = 1'b0;
        eff_ptgt = 32'd0;
        if (inf_v_q && (inf_pc_q == ID_PC_IN)) begin
            eff_pt   = inf_pt_q;
            eff_ptgt = inf_ptgt_q;
        end
    end

    always_comb begin
        mis_d = 1'b0;
        if (resolve) begin
            if (is_branch)
                mis_d = (is_taken != eff_pt) || (is_taken && (Alt_PC != eff_ptgt));
            else
                mis_d = eff_pt;
        end
        cpc_d = (is_taken && is_branch) ? Alt_PC : ID_Fallthrough_PC_IN;
    end

    assign capture = Fetch_Valid_IN && !FREEZE_IN && !mis_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= 32'd0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (resolve) begin
            if (is_branch) begin
                if (id_hit) begin
                    if (is_taken) begin
                        ctr_q[id_idx] <= (ctr_q[id_idx] == 2'b11) ? 2'b11 : ctr_q[id_idx] + 2'd1;
                        tgt_q[id_idx] <= Alt_PC;
                    end else begin
                        ctr_q[id_idx] <= (ctr_q[id_idx] == 2'b00) ? 2'b00 : ctr_q[id_idx] - 2'd1;
                    end
                end else if (is_taken) begin
                    valid_q[id_idx] <= 1'b1;
                    tag_q[id_idx]   <= id_tag;
                    tgt_q[id_idx]   <= Alt_PC;
                    ctr_q[id_idx]   <= 2'b10;
                end
            end else if (id_hit && eff_pt) begin
                valid_q[id_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inf_v_q    <= 1'b0;
            inf_pc_q   <= 32'd0;
            inf_pt_q   <= 1'b0;
            inf_ptgt_q <= 32'd0;
            mis_q      <= 1'b0;
            cpc_q      <= 32'd0;
            bcnt_q     <= 32'd0;
            mcnt_q     <= 32'd0;
        end else begin
            // A redirect flushes whatever fetch issued down the wrong path
            if (mis_d) begin
                inf_v_q <= 1'b0;
            end else if (capture) begin
                inf_v_q    <= 1'b1;
                inf_pc_q   <= Fetch_PC_IN;
                inf_pt_q   <= Pred_Taken_OUT;
                inf_ptgt_q <= Pred_Target_OUT;
            end
            mis_q <= mis_d;
            if (mis_d)
                cpc_q <= cpc_d;
            if (resolve && is_branch)
                bcnt_q <= bcnt_q + 32'd1;
            if (mis_d)
                mcnt_q <= mcnt_q + 32'd1;
        end
    end

    assign Mispredict_OUT       = mis_q;
    assign Correct_PC_OUT       = cpc_q;
    assign Branch_Count_OUT     = bcnt_q;
    assign Mispredict_Count_OUT = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_predictor.sv
// Bench for branch_resolve_predictor: directed scenarios then random traffic
// against a table-level reference model.
module tb_branch_resolve_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fpc;
    logic        fv;
    logic        frz;
    logic        ptk;
    logic [31:0] ptg;
    logic        idv;
    logic [31:0] idpc;
    logic [31:0] fall;
    logic        isb;
    logic        ist;
    logic [31:0] alt;
    logic        mis;
    logic [31:0] cpc;
    logic [31:0] bcnt;
    logic [31:0] mcnt;

    int cmp = 0;
    int bad = 0;

    // reference state
    bit          m_v   [16];
    int unsigned m_tag [16];
    int unsigned m_tgt [16];
    int          m_ctr [16];
    bit          q_v;
    int unsigned q_pc;
    bit          q_pt;
    int unsigned q_tgt;
    bit          m_mis;
    int unsigned m_cpc;
    int unsigned m_bc;
    int unsigned m_mc;

    branch_resolve_predictor #(.IDX_BITS(4)) dut (
        .CLK(clk),
        .RESET(rst),
        .Fetch_PC_IN(fpc),
        .Fetch_Valid_IN(fv),
        .FREEZE_IN(frz),
        .Pred_Taken_OUT(ptk),
        .Pred_Target_OUT(ptg),
        .ID_Valid_IN(idv),
        .ID_PC_IN(idpc),
        .ID_Fallthrough_PC_IN(fall),
        .is_branch(isb),
        .is_taken(ist),
        .Alt_PC(alt),
        .Mispredict_OUT(mis),
        .Correct_PC_OUT(cpc),
        .Branch_Count_OUT(bcnt),
        .Mispredict_Count_OUT(mcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_v[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
    endfunction

    function automatic bit m_ptk(input int unsigned pc);
        return m_hit(pc) && m_ctr[idx_of(pc)] >= 2;
    endfunction

    function automatic int unsigned m_ptg(input int unsigned pc);
        return m_ptk(pc) ? m_tgt[idx_of(pc)] : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        q_v = 0; q_pc = 0; q_pt = 0; q_tgt = 0;
        m_mis = 0; m_cpc = 0; m_bc = 0; m_mc = 0;
    endtask

    // What the next clock edge does, given current inputs
    task automatic model_edge();
        bit          res, ept, nmis;
        int unsigned etg, i;
        bit          fpt;
        int unsigned ftg;
        if (rst) begin
            model_reset();
            return;
        end
        fpt  = m_ptk(fpc);
        ftg  = m_ptg(fpc);
        res  = idv && !frz;
        ept  = (q_v && q_pc == idpc) ? q_pt : 0;
        etg  = (q_v && q_pc == idpc) ? q_tgt : 0;
        nmis = 0;
        if (res) begin
            if (isb) nmis = (ist != ept) || (ist && alt != etg);
            else     nmis = ept;
            i = idx_of(idpc);
            if (isb) begin
                m_bc++;
                if (m_hit(idpc)) begin
                    if (ist) begin
                        if (m_ctr[i] < 3) m_ctr[i]++;
                        m_tgt[i] = alt;
                    end else if (m_ctr[i] > 0) m_ctr[i]--;
                end else if (ist) begin
                    m_v[i] = 1; m_tag[i] = tag_of(idpc); m_tgt[i] = alt; m_ctr[i] = 2;
                end
            end else if (m_hit(idpc) && ept) begin
                m_v[i] = 0;
            end
        end
        if (nmis) q_v = 0;
        else if (fv && !frz && !m_mis) begin
            q_v = 1; q_pc = fpc; q_pt = fpt; q_tgt = ftg;
        end
        if (nmis) begin
            m_mc++;
            m_cpc = (ist && isb) ? alt : fall;
        end
        m_mis = nmis;
    endtask

    // Compare at the falling edge, then advance the model through the rising edge
    task automatic step();
        @(negedge clk);
        chk("pred_taken", {31'd0, ptk}, {31'd0, m_ptk(fpc)});
        chk("pred_target", ptg, m_ptg(fpc));
        chk("mispredict", {31'd0, mis}, {31'd0, m_mis});
        if (m_mis) chk("correct_pc", cpc, m_cpc);
        chk("branch_count", bcnt, m_bc);
        chk("mispredict_count", mcnt, m_mc);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fv = 0; idv = 0; isb = 0; ist = 0; frz = 0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        idle(); fv = 1; fpc = pc; step();
    endtask

    task automatic resolve(input logic [31:0] pc, input bit b, input bit t,
                           input logic [31:0] a, input logic [31:0] f);
        idle(); idv = 1; idpc = pc; isb = b; ist = t; alt = a; fall = f; step();
        idle();
    endtask

    initial begin
        model_reset();
        rst = 1; fpc = 0; idpc = 0; fall = 0; alt = 0;
        idle();
        step(); step();
        rst = 0;
        fpc = 32'h00400010; #1;
        chk("rst_pred", {31'd0, ptk}, 32'd0);
        chk("rst_mis", {31'd0, mis}, 32'd0);
        chk("rst_cpc", cpc, 32'd0);
        chk("rst_bc", bcnt, 32'd0);
        chk("rst_mc", mcnt, 32'd0);

        // cold taken branch
        fetch(32'h00400010);
        resolve(32'h00400010, 1, 1, 32'h00400100, 32'h00400014);
        fpc = 32'h00400010; #1;
        chk("cold_mis", {31'd0, mis}, 32'd1);
        chk("cold_cpc", cpc, 32'h00400100);
        chk("cold_bc", bcnt, 32'd1);
        chk("cold_mc", mcnt, 32'd1);
        chk("cold_ptk", {31'd0, ptk}, 32'd1);
        chk("cold_ptg", ptg, 32'h00400100);
        step();
        chk("cold_pulse", {31'd0, mis}, 32'd0);

        // repeat taken, correctly predicted
        fetch(32'h00400010);
        resolve(32'h00400010, 1, 1, 32'h00400100, 32'h00400014);
        chk("rep_mis", {31'd0, mis}, 32'd0);
        chk("rep_bc", bcnt, 32'd2);
        chk("rep_mc", mcnt, 32'd1);

        // two not-taken resolutions: 11 -> 10 -> 01
        fetch(32'h00400010);
        resolve(32'h00400010, 1, 0, 32'h00400100, 32'h00400018);
        chk("nt1_mis", {31'd0, mis}, 32'd1);
        chk("nt1_cpc", cpc, 32'h00400018);
        step();
        fetch(32'h00400010);
        resolve(32'h00400010, 1, 0, 32'h00400100, 32'h00400018);
        chk("nt2_mis", {31'd0, mis}, 32'd1);
        chk("nt2_mc", mcnt, 32'd3);
        step();
        fpc = 32'h00400010; #1;
        chk("nt_pred", {31'd0, ptk}, 32'd0);

        // retrain taken, then alias at the same index
        fetch(32'h00400010);
        resolve(32'h00400010, 1, 1, 32'h00400100, 32'h00400014);
        step();
        fpc = 32'h00400050; #1;
        chk("alias_pred", {31'd0, ptk}, 32'd0);

        // freeze with a taken branch in ID
        fetch(32'h00400010);
        idle(); idv = 1; idpc = 32'h00400010; isb = 1; ist = 1;
        alt = 32'h00400100; fall = 32'h00400014; frz = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("frz_mis", {31'd0, mis}, 32'd0);
            chk("frz_bc", bcnt, 32'd5);
        end
        frz = 0;
        step();
        idle();
        chk("thaw_bc", bcnt, 32'd6);
        chk("thaw_mis", {31'd0, mis}, 32'd0);
        step();
        chk("thaw_once", bcnt, 32'd6);

        // non-branch predicted taken invalidates the entry
        fetch(32'h00400010);
        resolve(32'h00400010, 0, 0, 32'h00400100, 32'h00400014);
        fpc = 32'h00400010; #1;
        chk("nb_mis", {31'd0, mis}, 32'd1);
        chk("nb_cpc", cpc, 32'h00400014);
        chk("nb_mc", mcnt, 32'd5);
        chk("nb_inval", {31'd0, ptk}, 32'd0);
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 99) < 2);
            frz  = ($urandom_range(0, 99) < 10);
            fv   = ($urandom_range(0, 99) < 85);
            idv  = ($urandom_range(0, 99) < 85);
            fpc  = 32'h00400000 + ($urandom_range(0, 1) << 6) + ($urandom_range(0, 15) << 2);
            if (q_v && $urandom_range(0, 3) != 0) idpc = q_pc;
            else idpc = 32'h00400000 + ($urandom_range(0, 1) << 6) + ($urandom_range(0, 15) << 2);
            isb  = ($urandom_range(0, 9) < 7);
            ist  = $urandom_range(0, 1);
            alt  = $urandom_range(0, 1) ? 32'h00400100 : 32'h00400200;
            fall = idpc + 32'd4;
            step();
        end
        rst = 0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_predictor.md
# branch_resolve_predictor

Fetch-side branch predictor that closes the loop with the decode stage. It gives fetch a taken/target prediction for the current fetch PC from a direct-mapped BTB with 2-bit counters, and remembers the prediction made for the instruction now in ID. It compares that prediction against ID's resolution (`is_branch`, `is_taken`, `Alt_PC`), trains the table, and issues a registered redirect on a mispredict. It sits between the fetch PC mux and ID, and counts branches and mispredicts for the simulator.

## Interface
Parameters:
- `IDX_BITS`, default 4: BTB index width; the BTB has 2^IDX_BITS entries. Index = PC[IDX_BITS+1:2]. Tag = PC[31:IDX_BITS+2].

Ports:
- `CLK` in 1: the single clock.
- `RESET` in 1: synchronous, active-high reset.
- `Fetch_PC_IN` in 32: PC being fetched this cycle.
- `Fetch_Valid_IN` in 1: fetch is issuing `Fetch_PC_IN` to ID at the next edge.
- `FREEZE_IN` in 1: pipeline frozen (ID WANT_FREEZE).
- `Pred_Taken_OUT` out 1: combinational prediction for `Fetch_PC_IN`.
- `Pred_Target_OUT` out 32: combinational predicted target; 0 when not taken.
- `ID_Valid_IN` in 1: ID holds a real (non-bubble) instruction.
- `ID_PC_IN` in 32: PC of the instruction in ID.
- `ID_Fallthrough_PC_IN` in 32: not-taken continuation PC supplied by integration.
- `is_branch` in 1: the ID instruction is a branch or jump.
- `is_taken` in 1: ID resolved it as taken.
- `Alt_PC` in 32: ID's resolved target.
- `Mispredict_OUT` out 1: registered one-cycle redirect request.
- `Correct_PC_OUT` out 32: redirect PC, valid while `Mispredict_OUT` is 1.
- `Branch_Count_OUT` out 32: number of resolved branches.
- `Mispredict_Count_OUT` out 32: number of mispredicts.

## Operation
- BTB entry fields: valid, tag, target[31:0], ctr[1:0].
- Lookup: a hit is valid && tag match. `Pred_Taken_OUT` = hit && ctr[1]. `Pred_Target_OUT` = entry target when taken, else 0. There is no bypass: a lookup in the same cycle as a write sees the old entry.
- Inflight register {v, pc, ptaken, ptarget}. At an edge with Fetch_Valid_IN && !FREEZE_IN && !Mispredict_OUT, it captures the current lookup result and sets v. Otherwise it holds, except for the flush rule below.
- Resolution happens on a cycle with ID_Valid_IN && !FREEZE_IN. The effective prediction is (ptaken, ptarget) if v && pc==ID_PC_IN, else (0, 0).
- Mispredict conditions:
  - a branch whose `is_taken` differs from the predicted direction;
  - a branch with `is_taken` high and `Alt_PC` different from ptarget;
  - a non-branch that was predicted taken.
- Correct PC = is_taken && is_branch ? Alt_PC : ID_Fallthrough_PC_IN.
- On a mispredict edge: `Mispredict_OUT` is set to 1 and `Correct_PC_OUT` is loaded; inflight v is cleared, discarding the wrong-path capture. On the next edge `Mispredict_OUT` returns to 0 unless a new mispredict is detected.
- Training happens on the resolution edge, for a branch:
  - Tag hit: ctr saturating +1 if taken, −1 if not taken (bounds 00..11). Target is set to Alt_PC if taken.
  - Miss and taken: allocate the entry with valid=1, new tag, target=Alt_PC, ctr=10.
  - Miss and not taken: no write.
- Training for a non-branch that hit and was predicted taken: clear the entry's valid bit.
- Counters: `Branch_Count_OUT` increments by 1 per resolved branch. `Mispredict_Count_OUT` increments by 1 per mispredict. Both are 32-bit and wrap modulo 2^32.

## Timing
- Reset state: all BTB valid bits 0, all ctr 01, inflight v 0. Outputs `Mispredict_OUT`, `Correct_PC_OUT`, `Branch_Count_OUT` and `Mispredict_Count_OUT` are 0. `Pred_Taken_OUT` and `Pred_Target_OUT` read 0 because every entry is invalid.
- Reset wins over all simultaneous events. Reset during an active mispredict drops `Mispredict_OUT` at that edge.
- Latency: fetch at cycle N → ID resolves at N+1 → `Mispredict_OUT` and `Correct_PC_OUT` at N+2, a one-cycle pulse. The BTB update is visible to lookups from N+2.
- FREEZE_IN high: no capture, no resolution, no table or counter update. Inflight holds; `Mispredict_OUT` still deasserts after its one cycle.
- ID_Valid_IN low (bubble): no resolution, no update.
- A mispredict and a fetch capture on the same edge: the flush wins, so v ends at 0.

## Test plan
- **Reset:** assert RESET 2 cycles → all outputs 0; lookup of 0x00400010 gives Pred_Taken_OUT=0.
- **Cold taken branch:** fetch 0x00400010; next cycle ID gives is_branch=1, is_taken=1, Alt_PC=0x00400100 → next cycle Mispredict_OUT=1 for 1 cycle, Correct_PC_OUT=0x00400100, counts 1/1. A later lookup of 0x00400010 gives taken, target 0x00400100.
- **Repeat taken:** run the same branch again → no mispredict, ctr=11, counts 2/1.
- **Not-taken training:** starting from ctr=11, two not-taken resolutions with fallthrough 0x00400018 → first resolution mispredicts with Correct_PC_OUT=0x00400018; ctr goes 10 then 01; the next lookup predicts not taken.
- **Aliasing (IDX_BITS=4):** train 0x00400010 taken, then fetch 0x00400050 (same index, different tag) → Pred_Taken_OUT=0. If 0x00400050 were instead a hit as a non-branch predicted taken, the entry is invalidated and Correct_PC_OUT = fallthrough.
- **Freeze:** FREEZE_IN high for 3 cycles with a taken branch in ID → no counter or table change and no Mispredict_OUT; after release, resolution occurs exactly once and counts increment by 1.
